// File: rtl/fetch_pkg.sv
// Shared fetch-side types for the BTB update path: update-entry struct, branch types, defaults.
package fetch_pkg;

  localparam int SIZE_PC              = 32;
  localparam int BRANCH_TYPE          = 2;
  localparam int UPD_DEPTH_DEFAULT    = 4;
  localparam int STARVE_LIMIT_DEFAULT = 8;

  typedef enum logic [BRANCH_TYPE-1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } branch_type_e;

  typedef struct packed {
    logic [SIZE_PC-1:0]     pc;
    logic [SIZE_PC-1:0]     target;
    logic [BRANCH_TYPE-1:0] ctrlType;
    logic                   dir;
  } upd_entry_t;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/btb_update_arbiter_if.sv
// Update-in / table-write-out / fetch-grant bundle of btb_update_arbiter.
interface btb_update_arbiter_if import fetch_pkg::*; #(
  parameter int UPD_DEPTH = UPD_DEPTH_DEFAULT
) ();
  localparam int CW = $clog2(UPD_DEPTH) + 1;

  logic                   updValid_i;
  logic [SIZE_PC-1:0]     updPC_i;
  logic [SIZE_PC-1:0]     updTarget_i;
  logic [BRANCH_TYPE-1:0] updCtrlType_i;
  logic                   updDir_i;
  logic                   fetchReq_i;
  logic                   fetchGrant_o;
  logic                   tblWe_o;
  logic [SIZE_PC-1:0]     tblPC_o;
  logic [SIZE_PC-1:0]     tblTarget_o;
  logic [BRANCH_TYPE-1:0] tblCtrlType_o;
  logic                   tblDir_o;
  logic                   updDrop_o;
  logic [CW-1:0]          updCount_o;

  modport slave (
    input  updValid_i, updPC_i, updTarget_i, updCtrlType_i, updDir_i, fetchReq_i,
    output fetchGrant_o, tblWe_o, tblPC_o, tblTarget_o, tblCtrlType_o, tblDir_o,
           updDrop_o, updCount_o
  );

  modport master (
    output updValid_i, updPC_i, updTarget_i, updCtrlType_i, updDir_i, fetchReq_i,
    input  fetchGrant_o, tblWe_o, tblPC_o, tblTarget_o, tblCtrlType_o, tblDir_o,
           updDrop_o, updCount_o
  );
endinterface

// File: rtl/upd_fifo.sv
// Circular update buffer with occupancy count and head read.
// BTB_UPD_COALESCE_EN adds a PC-match/overwrite port (youngest matching entry wins).
module upd_fifo import fetch_pkg::*; #(
  parameter int DEPTH = UPD_DEPTH_DEFAULT,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  upd_entry_t    push_data_i,
  input  logic          pop_i,
`ifdef BTB_UPD_COALESCE_EN
  input  logic          ovw_i,
  output logic          hit_o,
`endif
  output upd_entry_t    head_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_nxt_o
);

  upd_entry_t    mem_q [DEPTH];
  upd_entry_t    mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

`ifdef BTB_UPD_COALESCE_EN
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] scan_idx;

  // Scan oldest to youngest so the last hit is the youngest; the entry leaving this cycle is excluded.
  always_comb begin
    hit_o    = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && !(pop_i && (k == 0)) &&
          (mem_q[scan_idx].pc == push_data_i.pc)) begin
        hit_o   = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end
`endif

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop_i)  head_d = head_q + PW'(1);
    if (push_i) tail_d = tail_q + PW'(1);
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[tail_q] = push_data_i;
`ifdef BTB_UPD_COALESCE_EN
    if (ovw_i) mem_d[hit_idx] = push_data_i;
`endif
  end

  // Storage is deliberately left out of reset; only pointers and count clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o      = mem_q[head_q];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;

endmodule

// File: rtl/btb_update_arbiter.sv
// Shares the single-ported BTB between fetch lookups and buffered commit-time updates.
// Optional in-FIFO coalescing of same-PC updates: define BTB_UPD_COALESCE_EN.
module btb_update_arbiter import fetch_pkg::*; #(
  parameter int UPD_DEPTH    = UPD_DEPTH_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  btb_update_arbiter_if.slave bus
);

  localparam int              CW         = $clog2(UPD_DEPTH) + 1;
  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   FULL       = CW'(UPD_DEPTH);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

  upd_entry_t    upd;
  upd_entry_t    head;
  logic [CW-1:0] count, count_nxt;
  logic          nonempty, pop, push, ovw, drop;
`ifdef BTB_UPD_COALESCE_EN
  logic          hit;
`endif

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          tbl_we_q, tbl_we_d;
  upd_entry_t    tbl_q, tbl_d;
  logic          drop_q, drop_d;

  always_comb begin
    upd.pc       = bus.updPC_i;
    upd.target   = bus.updTarget_i;
    upd.ctrlType = bus.updCtrlType_i;
    upd.dir      = bus.updDir_i;
  end

  upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (upd),
    .pop_i       (pop),
`ifdef BTB_UPD_COALESCE_EN
    .ovw_i       (ovw),
    .hit_o       (hit),
`endif
    .head_o      (head),
    .count_o     (count),
    .count_nxt_o (count_nxt)
  );

  // Table writes and lookup grants are mutually exclusive by construction.
  always_comb begin
    nonempty         = (count != '0);
    pop              = nonempty & (~bus.fetchReq_i | (state_q == ARB_FORCE));
    bus.fetchGrant_o = bus.fetchReq_i & ~((state_q == ARB_FORCE) & nonempty);
`ifdef BTB_UPD_COALESCE_EN
    ovw              = bus.updValid_i & hit;
`else
    ovw              = 1'b0;
`endif
    push             = bus.updValid_i & ~ovw & ((count < FULL) | pop);
    drop             = bus.updValid_i & ~ovw & ~push;
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || !nonempty)          starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);

    state_d = state_q;
    case (state_q)
      ARB_NORMAL: if ((starve_d == STARVE_MAX) || (count_nxt == FULL)) state_d = ARB_FORCE;
      ARB_FORCE:  if (pop || !nonempty) state_d = ARB_NORMAL;
      default:    state_d = ARB_NORMAL;
    endcase
  end

  always_comb begin
    tbl_we_d = pop;
    tbl_d    = tbl_q;
    if (pop) tbl_d = head;
    drop_d   = drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
      tbl_we_q <= 1'b0;
      tbl_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tbl_we_q <= tbl_we_d;
      tbl_q    <= tbl_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.tblWe_o       = tbl_we_q;
  assign bus.tblPC_o       = tbl_q.pc;
  assign bus.tblTarget_o   = tbl_q.target;
  assign bus.tblCtrlType_o = tbl_q.ctrlType;
  assign bus.tblDir_o      = tbl_q.dir;
  assign bus.updDrop_o     = drop_q;
  assign bus.updCount_o    = count;

endmodule

// File: doc/btb_update_arbiter.md
# btb_update_arbiter

Shares the single-ported BTB/branch-predictor table between front-end lookups and the commit-time training updates emitted by the CTI queue. Updates are buffered in a small FIFO and written only in cycles with no lookup, unless they have waited too long or the buffer is full. In those cases a forced write steals one lookup cycle. The block sits between the CTI queue update outputs and the table write port, beside fetch stage 1.

## Interface
Parameters:
- `UPD_DEPTH`, 4: number of update FIFO entries; must be a power of 2, at least 2.
- `STARVE_LIMIT`, 8: number of cycles a non-empty FIFO may go without a write before a forced write.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `updValid_i`, in, 1: the CTI queue presents a training update this cycle. There is no back-pressure on this input.
- `updPC_i`, in, `SIZE_PC`: PC of the branch being trained.
- `updTarget_i`, in, `SIZE_PC`: resolved target address.
- `updCtrlType_i`, in, `BRANCH_TYPE`: control type of the branch.
- `updDir_i`, in, 1: resolved direction.
- `fetchReq_i`, in, 1: fetch stage 1 requests a table lookup this cycle.
- `fetchGrant_o`, out, 1: the lookup is granted. This output is combinational.
- `tblWe_o`, out, 1: table write enable. Registered.
- `tblPC_o`, out, `SIZE_PC`: write index/tag. Registered.
- `tblTarget_o`, out, `SIZE_PC`: write data. Registered.
- `tblCtrlType_o`, out, `BRANCH_TYPE`: write data. Registered.
- `tblDir_o`, out, 1: write data. Registered.
- `updDrop_o`, out, 1: one-cycle pulse when an update is discarded. Registered.
- `updCount_o`, out, log2(`UPD_DEPTH`)+1: current FIFO occupancy.

## Operation
- **FIFO.** Circular buffer with head/tail pointers and an occupancy counter. Each entry holds {pc, target, type, dir}.
- **Write decision.** Let `pop` = (count != 0) & (~fetchReq_i | force_q).
  - `fetchGrant_o` = fetchReq_i & ~(force_q & count != 0).
  - Table-write and lookup grant are therefore never both given in one cycle.
- **Push rule.** When updValid_i is high, the update is pushed if count < `UPD_DEPTH` or `pop` is high in the same cycle (simultaneous push and pop at full is accepted).
  - Otherwise the update is dropped, and updDrop_o is high in the next cycle.
- **Starvation counter `starve_q`.**
  - Cleared on `pop` or when count == 0.
  - Otherwise increments, saturating at `STARVE_LIMIT`.
- **FSM, registered bit `force_q`, two states:**
  - NORMAL → FORCE when, on the next-state values, starve == `STARVE_LIMIT` or count == `UPD_DEPTH`.
  - FORCE → NORMAL after exactly one cycle in which `pop` occurred.
  - FORCE with an empty FIFO (possible only after reset) returns to NORMAL.
- **Pointer wrap.** Pointers wrap modulo `UPD_DEPTH` with no extra logic beyond the power-of-2 width.

## Timing
- `pop` in cycle N produces tblWe_o = 1 with the head entry's fields in cycle N+1.
- An update pushed in cycle N is first eligible for `pop` in cycle N+1. Minimum latency from updValid_i to tblWe_o is therefore 2 cycles.
- fetchGrant_o has zero latency.
- A forced write costs the front end exactly one lookup cycle.
- Worst-case write wait from reaching the FIFO head is `STARVE_LIMIT`+1 cycles.
- **Reset (asynchronous, reset = 0):**
  - count = 0, pointers = 0, starve_q = 0, force_q = NORMAL.
  - tblWe_o = 0, all tbl* data outputs = 0, updDrop_o = 0.
  - fetchGrant_o follows fetchReq_i.
  - Updates arriving during or before reset are lost; no partial write is emitted.
- FIFO contents are not cleared on reset. Only pointers and count are cleared.

## Configuration
- `BTB_UPD_COALESCE_EN` defined:
  - An incoming update whose PC matches a valid FIFO entry other than the one being popped this cycle overwrites that entry in place.
  - No push occurs and count is unchanged.
  - The update is never dropped, even when the FIFO is full.
  - If several entries match, the youngest is overwritten.
- `BTB_UPD_COALESCE_EN` undefined: every update follows the plain push rule. Duplicate PCs occupy separate entries and are written in order.

## Structure
- Shared package `fetch_pkg`:
  - the update-entry struct {pc, target, ctrlType, dir};
  - `BRANCH_TYPE` encodings;
  - default `UPD_DEPTH` and `STARVE_LIMIT`.
- One sub-module, `upd_fifo`: the parameterised circular buffer with count, head read, and an optional (macro-gated) associative PC-match/overwrite port.
- Arbitration, the FSM and the output registers stay in the top level.

## Test plan
- **Idle write.** fetchReq_i = 0; one update {PC=0x400, target=0x800, dir=1} in cycle 0. Expected: tblWe_o = 1 in cycle 2 with those fields; count returns to 0.
- **Starvation.** fetchReq_i held at 1; one update in cycle 0; `STARVE_LIMIT` = 8. Expected: fetchGrant_o = 0 for exactly one cycle (cycle 9), then tblWe_o = 1 in cycle 10, then grants resume.
- **Overflow.** fetchReq_i = 1; five updates in consecutive cycles; `UPD_DEPTH` = 4. Expected: FORCE is entered after the 4th update. The 5th update is accepted because it coincides with a pop; no drop pulse. Repeat with six back-to-back updates: exactly one updDrop_o pulse.
- **Coalesce on.** With `BTB_UPD_COALESCE_EN`, fetchReq_i = 1: PC=0x100 (dir=0), then PC=0x100 (dir=1). Expected: count = 1, and the eventual write carries dir = 1. With the macro undefined: count = 2 and two writes occur in order.
- **Reset mid-operation.** Assert reset with count = 3 and force_q = 1. Expected: all outputs go to their reset values immediately. After release: no tblWe_o until a new update arrives.
